// File: rtl/core_scheduler.sv
// Per-core instruction scheduler: walks each instruction through FETCH..UPDATE for a
// masked block of thread lanes, with LSU-wait watchdog, PC divergence flag and retire count.
module core_scheduler #(
  parameter int THREADS        = 4,
  parameter int PC_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [THREADS-1:0]           thread_mask,
  input  logic                         decoded_ret,
  input  logic [2:0]                   fetcher_state,
  input  logic [2*THREADS-1:0]         lsu_state,
  input  logic [PC_WIDTH*THREADS-1:0]  next_pc,
  output logic [PC_WIDTH-1:0]          current_pc,
  output logic [2:0]                   core_state,
  output logic [THREADS-1:0]           active_mask,
  output logic                         done,
  output logic                         diverged,
  output logic                         timeout,
  output logic [CNT_WIDTH-1:0]         retired
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [2:0] FETCHED = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_e;

  state_e                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [THREADS-1:0]    mask_q, mask_d;
  logic                  done_q, done_d;
  logic                  div_q, div_d;
  logic                  to_q, to_d;
  logic [CNT_WIDTH-1:0]  ret_q, ret_d;
  logic [WD_W-1:0]       wd_q, wd_d;

  logic                  busy;
  logic [PC_WIDTH-1:0]   lead_pc;
  logic                  pc_mismatch;

  // Only active lanes in REQUESTING/WAITING hold the core in WAIT.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < THREADS; i++) begin
      if (mask_q[i] && (lsu_state[2*i +: 2] == 2'b01 || lsu_state[2*i +: 2] == 2'b10))
        busy = 1'b1;
    end
  end

  // Scanning downward leaves the lowest-index active lane's PC as the leader.
  always_comb begin
    lead_pc     = '0;
    pc_mismatch = 1'b0;
    for (int i = THREADS - 1; i >= 0; i--) begin
      if (mask_q[i]) lead_pc = next_pc[PC_WIDTH*i +: PC_WIDTH];
    end
    for (int i = 0; i < THREADS; i++) begin
      if (mask_q[i] && (next_pc[PC_WIDTH*i +: PC_WIDTH] != lead_pc)) pc_mismatch = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    done_d  = done_q;
    div_d   = div_q;
    to_d    = to_q;
    ret_d   = ret_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d = thread_mask;
          if (thread_mask != '0) begin
            state_d = S_FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_FETCH:   if (fetcher_state == FETCHED) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!busy) begin
          state_d = S_EXECUTE;
        end else begin
          wd_d = wd_q + WD_W'(1);
          if (wd_q + WD_W'(1) == WD_MAX) begin
            to_d    = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        ret_d = ret_q + CNT_WIDTH'(1);
        if (decoded_ret) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          pc_d    = lead_pc;
          if (pc_mismatch) div_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      to_q    <= 1'b0;
      ret_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      div_q   <= div_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
      wd_q    <= wd_d;
    end
  end

  assign current_pc  = pc_q;
  assign core_state  = state_q;
  assign active_mask = mask_q;
  assign done        = done_q;
  assign diverged    = div_q;
  assign timeout     = to_q;
  assign retired     = ret_q;

endmodule
